// File: rtl/adc_dac_frame_scheduler_pkg.sv
// rtl/adc_dac_frame_scheduler_pkg.sv - shared types and widths for the ADC/DAC frame scheduler
// Purpose: FSM state encoding, ADC/DAC word widths and the sample-to-DAC expansion helper.
// Ports: none (package).
package adc_dac_frame_scheduler_pkg;

  localparam int ADC_W = 8;
  localparam int DAC_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADC_FRAME = 3'd1,
    ST_GAP       = 3'd2,
    ST_DAC_FRAME = 3'd3,
    ST_LOAD      = 3'd4
  } state_t;

  // The 8-bit sample becomes the top of the 12-bit DAC word; its upper nibble
  // is replicated into the low bits so full scale maps to full scale.
  function automatic logic [DAC_W-1:0] expand_sample(input logic [ADC_W-1:0] s);
    return {s, s[ADC_W-1 -: 4]};
  endfunction

endpackage

// File: rtl/adc_dac_frame_scheduler_sample_period_timer.sv
// rtl/adc_dac_frame_scheduler_sample_period_timer.sv - programmable sample-period timer
// Purpose: holds the period register and free-running counter, raises trigger at count 0.
// Ports:
//   i_serial_clock  serial clock, rising edge
//   i_reset         synchronous, active-high
//   i_enable        counter runs while high, held at 0 while low
//   i_period_load   1-cycle strobe: load i_period_value (0 is treated as 1)
//   i_period_value  new period in serial clocks
//   o_trigger       combinational: enable and counter at 0
module sample_period_timer #(
  parameter int PERIOD_WIDTH   = 16,
  parameter int DEFAULT_PERIOD = 64
) (
  input  logic                    i_serial_clock,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic                    i_period_load,
  input  logic [PERIOD_WIDTH-1:0] i_period_value,
  output logic                    o_trigger
);

  logic [PERIOD_WIDTH-1:0] r_period;
  logic [PERIOD_WIDTH-1:0] r_counter;
  logic [PERIOD_WIDTH-1:0] w_load_value;
  logic [PERIOD_WIDTH-1:0] w_eff_period;
  logic [PERIOD_WIDTH:0]   w_cnt_inc;

  // A period loaded this cycle already governs the wrap decision, so a counter
  // beyond the new period wraps on the very next edge.
  always_comb begin
    w_load_value = (i_period_value == '0) ? PERIOD_WIDTH'(1) : i_period_value;
    w_eff_period = i_period_load ? w_load_value : r_period;
    w_cnt_inc    = {1'b0, r_counter} + (PERIOD_WIDTH+1)'(1);
  end

  always_ff @(posedge i_serial_clock) begin
    if (i_reset) begin
      r_period  <= PERIOD_WIDTH'(DEFAULT_PERIOD);
      r_counter <= '0;
    end else begin
      if (i_period_load) begin
        r_period <= w_load_value;
      end
      if (!i_enable) begin
        r_counter <= '0;
      end else if (w_cnt_inc >= {1'b0, w_eff_period}) begin
        r_counter <= '0;
      end else begin
        r_counter <= w_cnt_inc[PERIOD_WIDTH-1:0];
      end
    end
  end

  assign o_trigger = i_enable && (r_counter == '0);

endmodule

// File: rtl/adc_dac_frame_scheduler.sv
// rtl/adc_dac_frame_scheduler.sv - ADC sample / DAC update round-trip sequencer
// Purpose: per sample period runs ADC frame, gap, DAC frame and ldac pulse; captures the
//          ADC sample, expands it to the DAC word and flags dropped triggers.
// Ports:
//   i_serial_clock, i_reset (sync, active-high), i_enable, i_period_load, i_period_value,
//   i_clear_overrun, i_adc_sample (valid on last ADC frame cycle)
//   o_sync_adc, o_sync_dac, o_ldac (active low), o_dac_word, o_sample_data,
//   o_sample_valid, o_busy, o_overrun (sticky)
module adc_dac_frame_scheduler
  import adc_dac_frame_scheduler_pkg::*;
#(
  parameter int FRAME_BITS     = 16,
  parameter int IDLE_GAP       = 2,
  parameter int LDAC_WIDTH     = 1,
  parameter int PERIOD_WIDTH   = 16,
  parameter int DEFAULT_PERIOD = 64
) (
  input  logic                    i_serial_clock,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic                    i_period_load,
  input  logic [PERIOD_WIDTH-1:0] i_period_value,
  input  logic                    i_clear_overrun,
  input  logic [ADC_W-1:0]        i_adc_sample,
  output logic                    o_sync_adc,
  output logic                    o_sync_dac,
  output logic                    o_ldac,
  output logic [DAC_W-1:0]        o_dac_word,
  output logic [ADC_W-1:0]        o_sample_data,
  output logic                    o_sample_valid,
  output logic                    o_busy,
  output logic                    o_overrun
);

  // Gap and ldac lengths share the frame phase counter and must fit in it.
  localparam int PHASE_W = $clog2(FRAME_BITS);
  localparam logic [PHASE_W-1:0] FRAME_LAST = PHASE_W'(FRAME_BITS - 1);
  localparam logic [PHASE_W-1:0] GAP_LAST   = PHASE_W'(IDLE_GAP - 1);
  localparam logic [PHASE_W-1:0] LDAC_LAST  = PHASE_W'(LDAC_WIDTH - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] w_next_phase;
  logic               w_trigger;
  logic               w_capture;
  logic               w_drop;
  logic               w_sync_adc_d;
  logic               w_sync_dac_d;
  logic               w_ldac_d;
  logic               w_busy_d;

  sample_period_timer #(
    .PERIOD_WIDTH  (PERIOD_WIDTH),
    .DEFAULT_PERIOD(DEFAULT_PERIOD)
  ) u_timer (
    .i_serial_clock(i_serial_clock),
    .i_reset       (i_reset),
    .i_enable      (i_enable),
    .i_period_load (i_period_load),
    .i_period_value(i_period_value),
    .o_trigger     (w_trigger)
  );

  always_ff @(posedge i_serial_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
    end else begin
      r_state <= w_next_state;
      r_phase <= w_next_phase;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_phase = r_phase + PHASE_W'(1);
    case (r_state)
      ST_IDLE: begin
        w_next_phase = '0;
        if (w_trigger) w_next_state = ST_ADC_FRAME;
      end
      ST_ADC_FRAME: begin
        if (r_phase == FRAME_LAST) begin
          w_next_state = ST_GAP;
          w_next_phase = '0;
        end
      end
      ST_GAP: begin
        if (r_phase == GAP_LAST) begin
          w_next_state = ST_DAC_FRAME;
          w_next_phase = '0;
        end
      end
      ST_DAC_FRAME: begin
        if (r_phase == FRAME_LAST) begin
          w_next_state = ST_LOAD;
          w_next_phase = '0;
        end
      end
      ST_LOAD: begin
        if (r_phase == LDAC_LAST) begin
          w_next_state = ST_IDLE;
          w_next_phase = '0;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_phase = '0;
      end
    endcase
  end

  // Strobes are decoded from the next state so the registered outputs line up
  // with the state they describe.
  always_comb begin
    w_sync_adc_d = (w_next_state != ST_ADC_FRAME);
    w_sync_dac_d = (w_next_state != ST_DAC_FRAME);
    w_ldac_d     = (w_next_state != ST_LOAD);
    w_busy_d     = (w_next_state != ST_IDLE);
    w_capture    = (r_state == ST_ADC_FRAME) && (r_phase == FRAME_LAST);
    w_drop       = w_trigger && (r_state != ST_IDLE);
  end

  always_ff @(posedge i_serial_clock) begin
    if (i_reset) begin
      o_sync_adc     <= 1'b1;
      o_sync_dac     <= 1'b1;
      o_ldac         <= 1'b1;
      o_busy         <= 1'b0;
      o_sample_valid <= 1'b0;
      o_sample_data  <= '0;
      o_dac_word     <= '0;
      o_overrun      <= 1'b0;
    end else begin
      o_sync_adc     <= w_sync_adc_d;
      o_sync_dac     <= w_sync_dac_d;
      o_ldac         <= w_ldac_d;
      o_busy         <= w_busy_d;
      o_sample_valid <= w_capture;
      if (w_capture) begin
        o_sample_data <= i_adc_sample;
        o_dac_word    <= expand_sample(i_adc_sample);
      end
      // A new drop takes priority over a simultaneous clear.
      if (w_drop) begin
        o_overrun <= 1'b1;
      end else if (i_clear_overrun) begin
        o_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_dac_frame_scheduler.sv
// tb/tb_adc_dac_frame_scheduler.sv - self-checking bench for adc_dac_frame_scheduler
module tb_adc_dac_frame_scheduler;

  localparam int FB  = 16;
  localparam int GAP = 2;
  localparam int LW  = 1;
  localparam int L   = 2*FB + GAP + LW;

  logic        clk = 1'b0;
  logic        r_in;
  logic        en;
  logic        load;
  logic [15:0] val;
  logic        clr;
  logic [7:0]  adc;
  logic        o_sync_adc, o_sync_dac, o_ldac, o_sample_valid, o_busy, o_overrun;
  logic [11:0] o_dac_word;
  logic [7:0]  o_sample_data;

  int total = 0;
  int bad   = 0;

  // Reference model: a round trip is described only by its start cycle.
  int m_cyc    = 0;
  bit m_has    = 0;
  int m_t0     = 0;
  int m_cnt    = 0;
  int m_period = 64;
  bit m_ovr    = 0;
  int m_data   = 0;
  int m_word   = 0;

  int base;
  int rel;
  int rel_in;

  always #5 clk = ~clk;

  adc_dac_frame_scheduler dut (
    .i_serial_clock (clk),
    .i_reset        (r_in),
    .i_enable       (en),
    .i_period_load  (load),
    .i_period_value (val),
    .i_clear_overrun(clr),
    .i_adc_sample   (adc),
    .o_sync_adc     (o_sync_adc),
    .o_sync_dac     (o_sync_dac),
    .o_ldac         (o_ldac),
    .o_dac_word     (o_dac_word),
    .o_sample_data  (o_sample_data),
    .o_sample_valid (o_sample_valid),
    .o_busy         (o_busy),
    .o_overrun      (o_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, m_cyc);
    end
  endtask

  task automatic step();
    int  k;
    bit  act;
    int  eff;
    bit  trig;
    if (r_in) begin
      m_has = 0; m_cnt = 0; m_period = 64; m_ovr = 0; m_data = 0; m_word = 0;
    end else begin
      k    = m_cyc - m_t0;
      act  = m_has && k >= 0 && k < L;
      eff  = load ? ((val == 0) ? 1 : int'(val)) : m_period;
      trig = en && (m_cnt == 0);
      if (load) m_period = eff;
      m_cnt = en ? ((m_cnt + 1 >= eff) ? 0 : m_cnt + 1) : 0;
      if (trig && act) m_ovr = 1;
      else if (clr)    m_ovr = 0;
      if (act && k == FB - 1) begin
        m_data = adc;
        m_word = {adc, adc[7:4]};
      end
      if (trig && !act) begin
        m_has = 1;
        m_t0  = m_cyc + 1;
      end
    end
    m_cyc++;
    @(posedge clk);
    #1;
    k   = m_cyc - m_t0;
    act = m_has && k >= 0 && k < L;
    chk("sync_adc", o_sync_adc, (act && k < FB) ? 0 : 1);
    chk("sync_dac", o_sync_dac, (act && k >= FB + GAP && k < 2*FB + GAP) ? 0 : 1);
    chk("ldac", o_ldac, (act && k >= 2*FB + GAP) ? 0 : 1);
    chk("busy", o_busy, act ? 1 : 0);
    chk("sample_valid", o_sample_valid, (act && k == FB) ? 1 : 0);
    chk("sample_data", o_sample_data, m_data);
    chk("dac_word", o_dac_word, m_word);
    chk("overrun", o_overrun, m_ovr);
    chk("sync_excl", o_sync_adc | o_sync_dac, 1);
  endtask

  initial begin
    // 1: reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      r_in = 1; en = 1'($urandom); load = 1'($urandom); val = 16'($urandom);
      clr = 1'($urandom); adc = 8'($urandom);
      step();
    end
    r_in = 0; en = 0; load = 0; val = 0; clr = 0; adc = 0;
    step();
    step();

    // 2 and 4: default period, then enable dropped during the second DAC frame
    base = m_cyc;
    adc  = 8'hA5;
    for (int i = 0; i < 150; i++) begin
      en = ((m_cyc - base) < 85);
      step();
      rel = m_cyc - base;
      case (rel)
        1:  chk("t2_adc_low_first", o_sync_adc, 0);
        16: chk("t2_adc_low_last", o_sync_adc, 0);
        17: begin
          chk("t2_adc_high", o_sync_adc, 1);
          chk("t2_valid", o_sample_valid, 1);
          chk("t2_data", o_sample_data, 8'hA5);
          chk("t2_word", o_dac_word, 12'hA5A);
        end
        19: chk("t2_dac_low_first", o_sync_dac, 0);
        34: chk("t2_dac_low_last", o_sync_dac, 0);
        35: begin
          chk("t2_ldac", o_ldac, 0);
          chk("t2_dac_high", o_sync_dac, 1);
        end
        36: chk("t2_idle", o_busy, 0);
        64: chk("t2_adc_not_yet", o_sync_adc, 1);
        65: chk("t2_adc_second", o_sync_adc, 0);
        99: chk("t4_ldac", o_ldac, 0);
        100: chk("t4_idle", o_busy, 0);
        default: ;
      endcase
      if (rel > 99) chk("t4_no_adc", o_sync_adc, 1);
    end
    chk("t4_counter", dut.u_timer.r_counter, 0);

    // 3: period 20, drop at 20, clear at 45, drop plus clear at 60
    r_in = 1; step(); r_in = 0;
    load = 1; val = 16'd20; en = 0; step(); load = 0;
    base = m_cyc;
    for (int i = 0; i < 80; i++) begin
      en     = 1;
      rel_in = m_cyc - base;
      clr    = (rel_in == 45) || (rel_in == 60);
      adc    = 8'($urandom);
      step();
      rel = m_cyc - base;
      case (rel)
        20: chk("t3_ovr_before", o_overrun, 0);
        21: chk("t3_ovr_set", o_overrun, 1);
        40: chk("t3_adc_not_yet", o_sync_adc, 1);
        41: chk("t3_adc_accept", o_sync_adc, 0);
        46: chk("t3_ovr_cleared", o_overrun, 0);
        61: chk("t3_ovr_wins", o_overrun, 1);
        default: ;
      endcase
    end
    clr = 0;

    // 5: reset on ADC frame cycle 8
    r_in = 1; step(); r_in = 0;
    base = m_cyc;
    adc  = 8'h3C;
    for (int i = 0; i < 30; i++) begin
      rel_in = m_cyc - base;
      r_in   = (rel_in == 8);
      en     = (rel_in <= 8);
      step();
      rel = m_cyc - base;
      if (rel == 9) begin
        chk("t5_adc_high", o_sync_adc, 1);
        chk("t5_idle", o_busy, 0);
      end
      chk("t5_no_valid", o_sample_valid, 0);
    end
    r_in = 0;

    // 6: period 0 -> back-to-back round trips
    r_in = 1; step(); r_in = 0;
    load = 1; val = 16'd0; en = 0; step(); load = 0;
    base = m_cyc;
    for (int i = 0; i < 110; i++) begin
      en  = 1;
      adc = 8'($urandom);
      step();
      rel = m_cyc - base;
      case (rel)
        2:  chk("t6_ovr", o_overrun, 1);
        35: chk("t6_ldac", o_ldac, 0);
        36: chk("t6_one_idle", o_busy, 0);
        37: chk("t6_restart", o_sync_adc, 0);
        72: chk("t6_one_idle2", o_busy, 0);
        73: chk("t6_restart2", o_sync_adc, 0);
        default: ;
      endcase
    end

    // Random traffic against the model
    for (int i = 0; i < 700; i++) begin
      r_in = ($urandom_range(0, 199) == 0);
      en   = ($urandom_range(0, 9) != 0);
      load = ($urandom_range(0, 29) == 0);
      val  = 16'($urandom_range(0, 80));
      clr  = ($urandom_range(0, 15) == 0);
      adc  = 8'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
